// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, stall-vector
// bit positions and the fetch FSM state encoding.
package if_fetch_unit_pkg;

    localparam int DATA_WIDTH = 32;

    // Positions inside the 6-bit ctrl stall vector.
    localparam int STOP_ID = 1;
    localparam int STOP_EX = 2;

    localparam logic NO_STOP = 1'b0;
    localparam logic STOP    = 1'b1;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    // ID stalled but EX free: IF/ID must present a nop rather than hold.
    function automatic logic is_id_bubble(input logic [5:0] stop_vec);
        return (stop_vec[STOP_ID] == STOP) && (stop_vec[STOP_EX] == NO_STOP);
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO holding {pc, inst} pairs between the memory
// response and the IF/ID register. Head is visible combinationally.
module if_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         clr,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [PW:0]   wr_ptr_reg;
    logic [PW:0]   rd_ptr_reg;
    logic          wr_en;
    logic          rd_en;

    assign wr_en = push && !full && !clr;
    assign rd_en = pop && !empty && !clr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                   (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign head  = mem_reg[rd_ptr_reg[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (wr_en && (wr_ptr_reg[PW-1:0] == PW'(gi)))
                    mem_reg[gi] <= push_data;
            end
        end
    endgenerate

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: req/ack fetch FSM towards instruction memory,
// response FIFO, and the registered IF/ID outputs with stall/flush handling.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int DW    = DATA_WIDTH,
    parameter int AW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_en,
    input  logic [AW-1:0] fetch_pc,
    input  logic [5:0]    stop,
    input  logic          flush,
    output logic          stallreq_if,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    output logic          id_valid,
    output logic [AW-1:0] id_pc,
    output logic [DW-1:0] id_inst
);

    if_state_e          state_reg;
    logic               fifo_full;
    logic               fifo_empty;
    logic [AW+DW-1:0]   fifo_head;
    logic               push;
    logic               pop;
    logic               unused_stop;

    assign unused_stop = ^{stop[5:3], stop[0]};

    assign push = (state_reg == IF_REQ) && imem_ack && !flush;
    assign pop  = !flush && (stop[STOP_ID] == NO_STOP) && !fifo_empty;

    // The PC holds until its own address is accepted, then advances on that edge.
    assign stallreq_if = fetch_en && !push;

    if_fifo #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({imem_addr, imem_rdata}),
        .pop       (pop),
        .clr       (flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IF_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            case (state_reg)
                IF_IDLE: begin
                    if (fetch_en && !flush && !fifo_full) begin
                        imem_addr <= fetch_pc;
                        imem_req  <= 1'b1;
                        state_reg <= IF_REQ;
                    end
                end
                IF_REQ: begin
                    // A flush arriving with the ack simply discards the data.
                    if (imem_ack) begin
                        imem_req  <= 1'b0;
                        state_reg <= IF_IDLE;
                    end else if (flush) begin
                        state_reg <= IF_DROP;
                    end
                end
                IF_DROP: begin
                    if (imem_ack) begin
                        imem_req  <= 1'b0;
                        state_reg <= IF_IDLE;
                    end
                end
                default: begin
                    imem_req  <= 1'b0;
                    state_reg <= IF_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_inst  <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_inst  <= '0;
        end else if (stop[STOP_ID] == STOP) begin
            if (is_id_bubble(stop)) begin
                id_valid <= 1'b0;
                id_inst  <= '0;
            end
        end else if (!fifo_empty) begin
            id_valid <= 1'b1;
            id_pc    <= fifo_head[AW+DW-1:DW];
            id_inst  <= fifo_head[DW-1:0];
        end else begin
            id_valid <= 1'b0;
            id_inst  <= '0;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a queue-based transaction model
// of the fetch stage, with directed scenarios pinning literal expectations.
module tb_if_fetch_unit;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fetch_en = 1'b0;
    logic [AW-1:0] fetch_pc = '0;
    logic [5:0]    stop = '0;
    logic          flush = 1'b0;
    logic          stallreq_if;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          id_valid;
    logic [AW-1:0] id_pc;
    logic [DW-1:0] id_inst;

    always #5 clk = ~clk;

    if_fetch_unit #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .fetch_pc    (fetch_pc),
        .stop        (stop),
        .flush       (flush),
        .stallreq_if (stallreq_if),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_inst     (id_inst)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    // Transaction-level model: an outstanding request, whether it is doomed,
    // the buffered pairs, and the IF/ID contents.
    ent_t        q[$];
    bit          m_busy;
    bit          m_drop;
    logic [31:0] m_addr;
    bit          m_idv;
    logic [31:0] m_idpc;
    logic [31:0] m_idinst;
    bit          m_popped;
    logic [31:0] pc_reg;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic bit accepted_now();
        return m_busy && !m_drop && imem_ack && !flush;
    endfunction

    task automatic model_reset();
        q.delete();
        m_busy = 0; m_drop = 0; m_addr = '0;
        m_idv = 0; m_idpc = '0; m_idinst = '0;
    endtask

    task automatic model_update();
        bit   acc;
        int   cnt0;
        ent_t e;
        acc      = accepted_now();
        cnt0     = q.size();
        m_popped = 0;
        if (flush) begin
            q.delete();
            m_idv = 0; m_idinst = '0;
        end else begin
            if (stop[1] && !stop[2]) begin
                m_idv = 0; m_idinst = '0;
            end else if (!stop[1]) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    m_idv = 1; m_idpc = e.pc; m_idinst = e.inst;
                    m_popped = 1;
                end else begin
                    m_idv = 0; m_idinst = '0;
                end
            end
            if (acc) begin
                e.pc = m_addr; e.inst = imem_rdata;
                q.push_back(e);
            end
        end
        if (acc) pc_reg = pc_reg + 32'd4;
        if (m_busy) begin
            if (imem_ack) begin
                m_busy = 0; m_drop = 0;
            end else if (flush) begin
                m_drop = 1;
            end
        end else if (fetch_en && !flush && cnt0 < DEPTH) begin
            m_busy = 1; m_addr = fetch_pc;
        end
    endtask

    task automatic check_regs();
        check("imem_req",  {31'b0, imem_req}, {31'b0, m_busy});
        check("imem_addr", imem_addr, m_addr);
        check("id_valid",  {31'b0, id_valid}, {31'b0, m_idv});
        check("id_inst",   id_inst, m_idinst);
        if (m_idv) check("id_pc", id_pc, m_idpc);
    endtask

    task automatic drive(input bit fe, input logic [5:0] stp, input bit fl,
                         input bit ack_ok, input logic [31:0] tgt);
        fetch_en = fe;
        stop     = stp;
        flush    = fl;
        if (fl) pc_reg = tgt;
        fetch_pc   = pc_reg;
        imem_ack   = m_busy && ack_ok;
        imem_rdata = imem_ack ? rom(m_addr) : $urandom();
        #1;
        check("stallreq_if", {31'b0, stallreq_if}, {31'b0, fetch_en && !accepted_now()});
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_regs();
        if (m_popped) $display("ID  pc=%08h inst=%08h", m_idpc, m_idinst);
    endtask

    task automatic cyc(input bit fe, input logic [5:0] stp, input bit fl,
                       input bit ack_ok, input logic [31:0] tgt);
        drive(fe, stp, fl, ack_ok, tgt);
        tick();
    endtask

    task automatic settle_idle();
        for (int i = 0; i < 20 && m_busy; i++) cyc(1'b1, 6'b0, 1'b0, 1'b1, 32'h0);
        if (m_busy) bound_fail("settle_idle");
    endtask

    initial begin
        logic [5:0]  stp;
        logic [31:0] tgt;
        int          r;

        model_reset();
        pc_reg = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_imem_req",  {31'b0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_id_valid",  {31'b0, id_valid}, 32'd0);
        check("rst_id_pc",     id_pc, 32'd0);
        check("rst_id_inst",   id_inst, 32'd0);
        check("rst_stallreq",  {31'b0, stallreq_if}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait fetch from 0: one request every two cycles.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 6'b0, 1'b0, 1'b1, 32'h0);
            check("zw_stall", {31'b0, stallreq_if}, (k % 2 == 0) ? 32'd1 : 32'd0);
            tick();
            if (k % 2 == 0) begin
                check("zw_addr", imem_addr, 32'(2 * k));
                check("zw_req",  {31'b0, imem_req}, 32'd1);
            end
            if (k % 2 == 0 && k >= 2) begin
                check("zw_id_pc",   id_pc, 32'(2 * (k - 2)));
                check("zw_id_inst", id_inst, rom(32'(2 * (k - 2))));
            end
        end

        // Wait states at 0xC: request and address held, stall asserted.
        cyc(1'b1, 6'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 6'b0, 1'b0, 1'b0, 32'h0);
            check("ws_stall", {31'b0, stallreq_if}, 32'd1);
            tick();
            check("ws_addr", imem_addr, 32'hC);
            check("ws_req",  {31'b0, imem_req}, 32'd1);
        end
        drive(1'b1, 6'b0, 1'b0, 1'b1, 32'h0);
        check("ws_ack_stall", {31'b0, stallreq_if}, 32'd0);
        tick();

        // ID hold then bubble, memory always ready.
        for (int k = 0; k < 4; k++) cyc(1'b1, 6'b000110, 1'b0, 1'b1, 32'h0);
        cyc(1'b1, 6'b000010, 1'b0, 1'b1, 32'h0);
        check("bubble_valid", {31'b0, id_valid}, 32'd0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 6'b0, 1'b0, 1'b1, 32'h0);

        // Flush while request 0x20 is un-acked; ack arrives two cycles later.
        settle_idle();
        cyc(1'b1, 6'b0, 1'b1, 1'b0, 32'h20);
        cyc(1'b1, 6'b0, 1'b0, 1'b0, 32'h0);
        check("fl_addr20", imem_addr, 32'h20);
        cyc(1'b1, 6'b0, 1'b1, 1'b0, 32'h100);
        check("fl_req_held", {31'b0, imem_req}, 32'd1);
        check("fl_addr_held", imem_addr, 32'h20);
        cyc(1'b1, 6'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 6'b0, 1'b0, 1'b1, 32'h0);
        check("fl_drop_done", {31'b0, imem_req}, 32'd0);
        cyc(1'b1, 6'b0, 1'b0, 1'b0, 32'h0);
        check("fl_new_addr", imem_addr, 32'h100);
        for (int k = 0; k < 6; k++) cyc(1'b1, 6'b0, 1'b0, 1'b1, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 2500; n++) begin
            r   = $urandom_range(0, 9);
            stp = (r < 7) ? 6'b000000 : (r == 7) ? 6'b000010 : 6'b000110;
            stp[5:3] = 3'($urandom());
            stp[0]   = 1'($urandom());
            tgt = $urandom() & 32'h0000FFFC;
            cyc(($urandom_range(0, 19) != 0), stp, ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 2) != 0), tgt);
        end

        // Asynchronous reset in the middle of a request.
        settle_idle();
        for (int i = 0; i < 20 && !m_busy; i++) cyc(1'b1, 6'b0, 1'b0, 1'b0, 32'h0);
        if (!m_busy) bound_fail("wait_req");
        drive(1'b1, 6'b0, 1'b0, 1'b0, 32'h0);
        #1 rst = 1'b1;
        #1;
        check("arst_req",      {31'b0, imem_req}, 32'd0);
        check("arst_id_valid", {31'b0, id_valid}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_regs();
        cyc(1'b1, 6'b0, 1'b0, 1'b1, 32'h0);
        check("arst_restart", imem_addr, pc_reg);
        for (int k = 0; k < 8; k++) cyc(1'b1, 6'b0, 1'b0, 1'b1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
